// File: rtl/filter2d_kxk_op.sv
// rtl/filter2d_kxk_op.sv - KxK signed 2D convolution, one tap per cycle, strobe output
// Zero-pad or edge-replicate borders; kernel writes only land while idle.
module filter2d_kxk_op #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16,
  parameter int K      = 3,
  parameter int SHIFT  = 6,
  parameter int ACC_W  = 22
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         border_mode,
  output logic                         busy,
  output logic                         done,
  output logic                         mem_rd,
  output logic [ADDR_W-1:0]            rd_addr,
  input  logic [7:0]                   rd_data,
  output logic                         o_strb,
  output logic [7:0]                   o_data,
  input  logic                         h_write,
  input  logic [$clog2(K*K)-1:0]       h_idx,
  input  logic [7:0]                   h_data
);

  localparam int KK = K * K;
  localparam int P  = KK + 3;
  localparam int R  = (K - 1) / 2;
  localparam int CW = $clog2(P);
  localparam int HW = $clog2(KK);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1 << (SHIFT - 1));

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q;
  logic [XW-1:0]            x_q;
  logic [YW-1:0]            y_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [7:0]               pd_q;
  logic                     tap_rd_q;
  logic                     border_q;
  logic                     o_strb_q;
  logic                     done_q;
  logic [7:0]               o_data_q;
  logic signed [7:0]        h_q [KK];

  logic                     tap_in;
  logic [ADDR_W-1:0]        tap_addr;
  logic                     last_px;
  logic                     px_end;
  logic signed [7:0]        coef_c;
  logic signed [16:0]       prod_c;
  logic signed [ACC_W-1:0]  sum_c;
  logic signed [ACC_W-1:0]  shr_c;
  logic [7:0]               clip_c;

  assign last_px = (x_q == XW'(IMG_W - 1)) && (y_q == YW'(IMG_H - 1));
  assign px_end  = (cnt_q == CW'(P - 1));

  // Tap coordinate for the current cnt, plus its clamped address for replicate mode.
  always_comb begin
    int t, tx, ty, cx, cy;
    t  = int'(cnt_q);
    tx = int'(x_q) + (t % K) - R;
    ty = int'(y_q) + (t / K) - R;
    tap_in = (tx >= 0) && (tx < IMG_W) && (ty >= 0) && (ty < IMG_H);
    cx = (tx < 0) ? 0 : ((tx > IMG_W - 1) ? IMG_W - 1 : tx);
    cy = (ty < 0) ? 0 : ((ty > IMG_H - 1) ? IMG_H - 1 : ty);
    tap_addr = ADDR_W'(cy * IMG_W + cx);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start && !abort) state_d = S_RUN;
      S_RUN: begin
        if (abort || (px_end && last_px)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == S_RUN);
    mem_rd  = busy && (cnt_q < CW'(KK)) && (border_q || tap_in);
    rd_addr = tap_addr;
  end

  // Coefficient for the tap whose pixel sits in pd_q this cycle (cnt 2..KK+1).
  always_comb begin
    coef_c = 8'sd0;
    for (int i = 0; i < KK; i++) begin
      if (int'(cnt_q) == i + 2) coef_c = h_q[i];
    end
    prod_c = $signed({9'd0, pd_q}) * $signed({{9{coef_c[7]}}, coef_c});
    sum_c  = acc_q + RND;
    shr_c  = sum_c >>> SHIFT;
    if (shr_c[ACC_W-1]) begin
      clip_c = 8'd0;
    end else if (|shr_c[ACC_W-2:8]) begin
      clip_c = 8'd255;
    end else begin
      clip_c = shr_c[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      pd_q     <= '0;
      tap_rd_q <= 1'b0;
      border_q <= 1'b0;
      o_strb_q <= 1'b0;
      done_q   <= 1'b0;
      o_data_q <= '0;
      for (int i = 0; i < KK; i++) begin
        h_q[i] <= (i == (KK - 1) / 2) ? 8'sd64 : 8'sd0;
      end
    end else begin
      o_strb_q <= 1'b0;
      done_q   <= 1'b0;
      tap_rd_q <= mem_rd;
      // Unread (zero-pad) taps enter the MAC as a zero pixel.
      pd_q     <= tap_rd_q ? rd_data : 8'd0;
      if (!busy && h_write) begin
        for (int i = 0; i < KK; i++) begin
          if (h_idx == HW'(i)) h_q[i] <= h_data;
        end
      end
      if (!busy) begin
        if (start && !abort) begin
          cnt_q    <= '0;
          x_q      <= '0;
          y_q      <= '0;
          acc_q    <= '0;
          border_q <= border_mode;
        end
      end else if (!abort) begin
        if (cnt_q == CW'(1)) begin
          acc_q <= '0;
        end else if (cnt_q >= CW'(2) && cnt_q <= CW'(KK + 1)) begin
          acc_q <= acc_q + {{(ACC_W-17){prod_c[16]}}, prod_c};
        end
        if (px_end) begin
          cnt_q    <= '0;
          o_strb_q <= 1'b1;
          o_data_q <= clip_c;
          done_q   <= last_px;
          if (x_q == XW'(IMG_W - 1)) begin
            x_q <= '0;
            y_q <= y_q + YW'(1);
          end else begin
            x_q <= x_q + XW'(1);
          end
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign o_strb = o_strb_q;
  assign done   = done_q;
  assign o_data = o_data_q;

endmodule

// File: tb/tb_filter2d_kxk_op.sv
// tb/tb_filter2d_kxk_op.sv - directed bench for filter2d_kxk_op (3x3 on 4x4, 5x5 on 8x8)
module tb_filter2d_kxk_op;

  localparam int NP  = 16;
  localparam int P3  = 12;
  localparam int NP5 = 64;
  localparam int P5  = 28;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start, abort, border_mode, busy, done, mem_rd, o_strb, h_write;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data, o_data, h_data;
  logic [3:0]  h_idx;

  logic        start5, abort5, bm5, busy5, done5, mem_rd5, o_strb5, h_write5;
  logic [15:0] rd_addr5;
  logic [7:0]  rd_data5, o_data5, h_data5;
  logic [4:0]  h_idx5;

  filter2d_kxk_op #(.IMG_W(4), .IMG_H(4), .ADDR_W(16), .K(3), .SHIFT(6), .ACC_W(22)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .border_mode(border_mode),
    .busy(busy), .done(done), .mem_rd(mem_rd), .rd_addr(rd_addr), .rd_data(rd_data),
    .o_strb(o_strb), .o_data(o_data), .h_write(h_write), .h_idx(h_idx), .h_data(h_data)
  );

  filter2d_kxk_op #(.IMG_W(8), .IMG_H(8), .ADDR_W(16), .K(5), .SHIFT(6), .ACC_W(22)) u_dut5 (
    .clk(clk), .reset_n(reset_n), .start(start5), .abort(abort5), .border_mode(bm5),
    .busy(busy5), .done(done5), .mem_rd(mem_rd5), .rd_addr(rd_addr5), .rd_data(rd_data5),
    .o_strb(o_strb5), .o_data(o_data5), .h_write(h_write5), .h_idx(h_idx5), .h_data(h_data5)
  );

  logic [7:0] img [NP];
  logic [7:0] img5 [NP5];

  always @(posedge clk) begin
    rd_data  <= mem_rd  ? img[rd_addr[3:0]]   : 8'hEE;
    rd_data5 <= mem_rd5 ? img5[rd_addr5[5:0]] : 8'hEE;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  int cyc = 0;
  int q[$];
  int q5[$];
  int done_n, done_pos, stray_done, busy_n, first_cyc;
  int done5_n, busy5_n, first5_cyc;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (busy) busy_n++;
    if (o_strb) begin
      if (q.size() == 0) first_cyc = cyc;
      q.push_back(int'(o_data));
    end
    if (done) begin
      done_n++;
      done_pos = q.size();
      if (!o_strb) stray_done++;
    end
    if (busy5) busy5_n++;
    if (o_strb5) begin
      if (q5.size() == 0) first5_cyc = cyc;
      q5.push_back(int'(o_data5));
    end
    if (done5) done5_n++;
  end

  task automatic clear_mon();
    q.delete();
    done_n = 0; done_pos = -1; stray_done = 0; busy_n = 0; first_cyc = -1;
  endtask

  task automatic set_tap(input int idx, input int val);
    h_write = 1'b1; h_idx = 4'(idx); h_data = 8'(val);
    @(negedge clk);
    h_write = 1'b0;
  endtask

  task automatic set_kernel(input int centre, input int others);
    for (int i = 0; i < 9; i++) set_tap(i, (i == 4) ? centre : others);
  endtask

  // One frame on the 3x3 instance; mid=1 also pokes a kernel write and a start while busy.
  task automatic run_frame(input string tag, input bit bm, input bit mid);
    int c0, n;
    clear_mon();
    border_mode = bm; start = 1'b1; c0 = cyc;
    @(negedge clk);
    start = 1'b0; border_mode = 1'b0;
    if (mid) begin
      repeat (20) @(negedge clk);
      set_tap(4, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (done_n == 0 && n < NP * P3 + 40) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    chk({tag, "_strobes"}, q.size(), NP);
    chk({tag, "_done_count"}, done_n, 1);
    chk({tag, "_done_pos"}, done_pos, NP);
    chk({tag, "_stray_done"}, stray_done, 0);
    chk({tag, "_busy_cycles"}, busy_n, NP * P3);
    chk({tag, "_latency"}, first_cyc - c0, P3 + 1);
    chk({tag, "_busy_after"}, int'(busy), 0);
  endtask

  task automatic chk_frame(input string tag, input int e[NP]);
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("%s_px%0d", tag, i), (i < q.size()) ? q[i] : -1, e[i]);
    end
  endtask

  int exp_a[NP];
  int exp_b[NP];

  initial begin
    int seen, t;
    reset_n = 1'b0;
    start = 0; abort = 0; border_mode = 0; h_write = 0; h_idx = 0; h_data = 0;
    start5 = 0; abort5 = 0; bm5 = 0; h_write5 = 0; h_idx5 = 0; h_data5 = 0;
    for (int i = 0; i < NP; i++) img[i] = 8'(16 * (i / 4) + (i % 4));
    for (int i = 0; i < NP5; i++) img5[i] = 8'd64;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_strb", int'(o_strb), 0);
    chk("rst_data", int'(o_data), 0);
    chk("rst_mem_rd", int'(mem_rd), 0);
    chk("rst_busy5", int'(busy5), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Identity kernel from reset; an out-of-range tap write must not alias.
    for (int i = 0; i < NP; i++) exp_a[i] = 16 * (i / 4) + (i % 4);
    set_tap(13, 100);
    run_frame("s1", 1'b0, 1'b0);
    chk_frame("s1", exp_a);

    clear_mon();
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (4) @(negedge clk);
    chk("start_abort_busy", int'(busy), 0);
    chk("start_abort_strobes", q.size(), 0);

    for (int i = 0; i < NP; i++) img[i] = 8'd100;
    set_kernel(8, 8);
    for (int i = 0; i < NP; i++) begin
      bit xe, ye;
      xe = (i % 4 == 0) || (i % 4 == 3);
      ye = (i / 4 == 0) || (i / 4 == 3);
      exp_b[i] = (xe && ye) ? 50 : ((xe || ye) ? 75 : 113);
    end
    run_frame("s2z", 1'b0, 1'b0);
    chk_frame("s2z", exp_b);
    for (int i = 0; i < NP; i++) exp_b[i] = 113;
    run_frame("s2r", 1'b1, 1'b0);
    chk_frame("s2r", exp_b);

    for (int i = 0; i < NP; i++) img[i] = 8'd200;
    set_kernel(127, 0);
    for (int i = 0; i < NP; i++) exp_b[i] = 255;
    run_frame("s3hi", 1'b0, 1'b0);
    chk_frame("s3hi", exp_b);
    for (int i = 0; i < NP; i++) img[i] = 8'd10;
    set_kernel(-64, 0);
    for (int i = 0; i < NP; i++) exp_b[i] = 0;
    run_frame("s3lo", 1'b1, 1'b0);
    chk_frame("s3lo", exp_b);

    // Abort during pixel 5 at cnt=4.
    for (int i = 0; i < NP; i++) img[i] = 8'(16 * (i / 4) + (i % 4));
    set_kernel(64, 0);
    clear_mon();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0; t = 0;
    while (seen < 5 && t < 1000) begin
      @(negedge clk);
      t++;
      if (o_strb) seen++;
    end
    chk("s4_reached_px5", seen, 5);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("s4_busy_after_abort", int'(busy), 0);
    chk("s4_mem_rd_after_abort", int'(mem_rd), 0);
    repeat (40) @(negedge clk);
    chk("s4_strobes", q.size(), 5);
    chk("s4_done", done_n, 0);
    run_frame("s4re", 1'b0, 1'b0);
    chk_frame("s4re", exp_a);

    run_frame("s5run", 1'b0, 1'b1);
    chk_frame("s5run", exp_a);
    set_tap(4, 0);
    for (int i = 0; i < NP; i++) exp_b[i] = 0;
    run_frame("s5idle", 1'b0, 1'b0);
    chk_frame("s5idle", exp_b);

    // Reset mid-frame restores the identity kernel.
    clear_mon();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_strb", int'(o_strb), 0);
    chk("mrst_mem_rd", int'(mem_rd), 0);
    reset_n = 1'b1;
    @(negedge clk);
    run_frame("mrst", 1'b0, 1'b0);
    chk_frame("mrst", exp_a);

    // 5x5 on 8x8, replicate, all taps 2, flat 64 image.
    for (int i = 0; i < 25; i++) begin
      h_write5 = 1'b1; h_idx5 = 5'(i); h_data5 = 8'd2;
      @(negedge clk);
    end
    h_write5 = 1'b0;
    q5.delete(); done5_n = 0; busy5_n = 0; first5_cyc = -1;
    bm5 = 1'b1; start5 = 1'b1; t = cyc;
    @(negedge clk);
    start5 = 1'b0; bm5 = 1'b0;
    seen = 0;
    while (done5_n == 0 && seen < NP5 * P5 + 100) begin
      @(negedge clk);
      seen++;
    end
    repeat (6) @(negedge clk);
    chk("s6_strobes", q5.size(), NP5);
    chk("s6_done", done5_n, 1);
    chk("s6_busy_cycles", busy5_n, NP5 * P5);
    chk("s6_latency", first5_cyc - t, P5 + 1);
    for (int i = 0; i < NP5; i++) begin
      chk($sformatf("s6_px%0d", i), (i < q5.size()) ? q5[i] : -1, 50);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/filter2d_kxk_op.md
Name: filter2d_kxk_op

Overview:
Parametrised K×K 2D convolution engine for the Filter2D datapath. It reads an 8-bit image from frame memory one tap per cycle and runs a signed multiply-accumulate. Each output pixel is rounded, shifted and clipped, then emitted on a strobe interface. It generalises the fixed 3×3 operator in four ways:
- kernel size and image dimensions are parameters;
- border handling is selectable at run time (zero-pad or edge-replicate);
- a busy/done status and an abort input are added;
- kernel writes are interlocked against an active frame.

Parameters:
IMG_W, 256, image width in pixels (≥ K).
IMG_H, 256, image height in pixels (≥ K).
ADDR_W, 16, rd_addr width (2^ADDR_W ≥ IMG_W·IMG_H).
K, 3, kernel size; odd, 3 or 5; R=(K-1)/2.
SHIFT, 6, right shift applied to the accumulator before clipping (1..10).
ACC_W, 22, accumulator width; must be ≥ 16+clog2(K·K)+1.

Ports:
clk  in  1  clock.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  one-cycle frame start; ignored while busy.
abort  in  1  one-cycle frame cancel.
border_mode  in  1  0=zero-pad, 1=replicate; sampled on accepted start.
busy  out  1  high while a frame is in progress.
done  out  1  one-cycle pulse on the final pixel.
mem_rd  out  1  memory read enable.
rd_addr  out  ADDR_W  read address = y·IMG_W + x.
rd_data  in  8  unsigned pixel, valid the cycle after mem_rd.
o_strb  out  1  output pixel valid, one cycle.
o_data  out  8  output pixel, raster order.
h_write  in  1  coefficient write strobe.
h_idx  in  clog2(K·K)  tap index, row-major; tap 0 is (dy,dx)=(-R,-R).
h_data  in  8  signed coefficient.

Behaviour:
- Reset values:
  - outputs: busy=0, done=0, o_strb=0, o_data=0, mem_rd=0; rd_addr don't-care.
  - internal: cnt, x, y and acc all 0.
  - kernel: all taps 0 except centre tap (index (K·K-1)/2) = 8'sd64, i.e. identity when SHIFT=6.
- Kernel writes:
  - h_write applies when busy=0; ignored while busy=1.
  - h_idx ≥ K·K is ignored.
- FSM states: IDLE, RUN.
  - IDLE→RUN on start; busy=1 from the next cycle.
  - RUN→IDLE after the last pixel's output cycle, or the cycle after abort.
  - start while busy is ignored.
  - abort has priority over all RUN activity.
- Pixel period P = K·K+3 cycles; cnt runs 0..P-1 per pixel.
  - After the pixel at cnt=P-1, x increments; at x=IMG_W-1 it wraps to 0 and y increments.
- Reads: at cnt=t<K·K, tap coordinates are (x+dx, y+dy), dx=(t mod K)-R, dy=(t div K)-R.
  - zero mode: mem_rd=0 for taps outside the image, and that tap contributes nothing to acc.
  - replicate mode: coordinates clamped to [0,IMG_W-1]×[0,IMG_H-1]; mem_rd=1 for every tap.
- Pipeline:
  - rd_data is registered into pd at cnt 1..K·K.
  - acc is cleared at cnt=1.
  - at cnt 2..K·K+1: acc += signed(0,pd)·h[cnt-2], only if the tap was read.
- Output: at cnt=P-1, r = (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic), clipped to [0,255].
  - o_strb=1 and o_data=r in the following cycle.
  - o_data holds its value between strobes.
- Latency: first o_strb P+1 cycles after the start edge. Frame length IMG_W·IMG_H·P cycles, followed by exactly IMG_W·IMG_H strobes.
- done=1 in the same cycle as the final o_strb; busy falls in that cycle.
- Abort mid-frame: the cycle after abort, busy=0, mem_rd=0 and no further strobes; no done. A subsequent start restarts at (0,0) with acc cleared.
- Simultaneous start and abort in IDLE: abort wins and the frame does not start.
- Reset mid-operation: return to reset state immediately; the kernel reverts to identity.

Test Plan:
1. IMG_W=IMG_H=4, K=3, default kernel, image p(x,y)=16y+x, start → 16 strobes with o_data = 0,1,2,3,16,…,51; done with the 16th; first strobe 13 cycles after start.
2. All pixels 100, all taps 8, zero mode:
   - corners → 50; edges (6 taps) → (4800+32)>>6 = 75; interior → 113.
   - in replicate mode, all 16 outputs → 113.
3. Clipping: centre tap 127, others 0, pixels 200 → 255. Centre tap -64, pixels 10 → 0 (r=-10).
4. Abort at pixel 5, cnt=4 → no strobe after the cycle following abort, busy=0, no done. Restart → the full 16 outputs of scenario 1.
5. h_write idx 4 = 0 during RUN → ignored, outputs unchanged. The same write in IDLE followed by start → all outputs 0. start while busy → no effect.
6. K=5, IMG 8×8, all taps 2, pixels 64, replicate, SHIFT=6 → every output = (3200+32)>>6 = 50; 64 strobes, P=28.
